// File: rtl/atm_pkg.sv
// atm_pkg: shared character and key-code definitions for the ATM front-panel blocks
package atm_pkg;
  localparam int CHAR_W = 5;
  localparam int N_CHARS = 8;
  localparam logic [4:0] CHAR_BLANK = 5'd31;
  localparam logic [3:0] KEY_C = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_ONE, SCAN_MULTI} scan_t;
  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD} deb_t;
  function automatic logic is_digit(input logic [3:0] k);
    return k inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd13};
  endfunction
  // key code (row*4+col) to the digit printed on the keycap
  function automatic logic [4:0] key_digit(input logic [3:0] k);
    case (k)
      4'd0: return 5'd1;
      4'd1: return 5'd2;
      4'd2: return 5'd3;
      4'd4: return 5'd4;
      4'd5: return 5'd5;
      4'd6: return 5'd6;
      4'd8: return 5'd7;
      4'd9: return 5'd8;
      4'd10: return 5'd9;
      default: return 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: column scanner, row synchroniser, scan classifier and debounce FSM
module keypad_scan
  import atm_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [DW-1:0] div;
  logic [1:0] col, acc_n, base, n_new, row_idx;
  logic [3:0] row_m, row_s, hits, acc_code, code_new, cand;
  logic [2:0] nb, tot;
  logic [CW-1:0] cnt, rel;
  logic slot_end;
  scan_t res;
  deb_t st;
  assign col_n = ~(4'b0001 << col);
  assign slot_end = div == DW'(SCAN_DIV - 1);
  // fold the current column into the running per-scan hit count
  always_comb begin
    hits = ~row_s;
    nb = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    base = col == 2'd0 ? 2'd0 : acc_n;
    tot = {1'b0, base} + nb;
    n_new = tot >= 3'd2 ? 2'd2 : tot[1:0];
    row_idx = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
    code_new = (nb == 3'd1 && base == 2'd0) ? {row_idx, col} : acc_code;
    res = n_new == 2'd0 ? SCAN_NONE : n_new == 2'd1 ? SCAN_ONE : SCAN_MULTI;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      col <= 2'd0;
      row_m <= 4'hF;
      row_s <= 4'hF;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
      st <= ST_IDLE;
      cand <= 4'd0;
      cnt <= '0;
      rel <= '0;
      key_valid <= 1'b0;
      key_code <= 4'd0;
    end else begin
      row_m <= row_n;
      row_s <= row_m;
      key_valid <= 1'b0;
      div <= slot_end ? '0 : div + 1'b1;
      if (slot_end) begin
        col <= col + 2'd1;
        acc_n <= n_new;
        acc_code <= code_new;
        if (col == 2'd3) begin
          case (st)
            ST_IDLE: if (res == SCAN_ONE) begin
              cand <= code_new;
              cnt <= CW'(1);
              rel <= '0;
              if (DEBOUNCE <= 1) begin
                key_valid <= 1'b1;
                key_code <= code_new;
                st <= ST_HELD;
              end else st <= ST_CONFIRM;
            end
            ST_CONFIRM: if (res == SCAN_ONE && code_new == cand) begin
              cnt <= cnt + CW'(1);
              if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
                key_valid <= 1'b1;
                key_code <= cand;
                rel <= '0;
                st <= ST_HELD;
              end
            end else begin
              cnt <= '0;
              st <= ST_IDLE;
            end
            ST_HELD: if (res == SCAN_NONE) begin
              if (rel + CW'(1) == CW'(DEBOUNCE)) begin
                rel <= '0;
                cnt <= '0;
                st <= ST_IDLE;
              end else rel <= rel + CW'(1);
            end else rel <= '0;
            default: st <= ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced keypad reader assembling digit entries into an 8-char display word
module keypad_entry
  import atm_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n,
  output logic [39:0] entry,
  output logic [3:0]  entry_len,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        enter,
  output logic        overflow
);
  logic dig;
  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .col_n(col_n),
    .row_n(row_n),
    .key_valid(key_valid),
    .key_code(key_code)
  );
  assign dig = is_digit(key_code);
  assign enter = key_valid && key_code == KEY_HASH;
  assign overflow = key_valid && dig && entry_len == 4'd8;
  // '#' clears after its pulse cycle so the consumer sees the finished entry alongside enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= {N_CHARS{CHAR_BLANK}};
      entry_len <= 4'd0;
    end else if (key_valid) begin
      if (dig && entry_len < 4'd8) begin
        entry <= {entry[34:0], key_digit(key_code)};
        entry_len <= entry_len + 4'd1;
      end else if (key_code == KEY_STAR && entry_len != 4'd0) begin
        entry <= {CHAR_BLANK, entry[39:5]};
        entry_len <= entry_len - 4'd1;
      end else if (key_code == KEY_C || key_code == KEY_HASH) begin
        entry <= {N_CHARS{CHAR_BLANK}};
        entry_len <= 4'd0;
      end
    end
  end
endmodule
